// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the instruction fetch path:
//   - 8-bit opcode constants of the ISA
//   - fetch FSM state encoding (fetch_state_t)
//   - is_branch(): classifies the opcodes that the fetch unit resolves itself
// No ports (package).
// -----------------------------------------------------------------------------
package isa_pkg;

   localparam logic [7:0] OP_NOP  = 8'd2;
   localparam logic [7:0] OP_LDAC = 8'd3;
   localparam logic [7:0] OP_STAC = 8'd4;
   localparam logic [7:0] OP_MVAC = 8'd5;
   localparam logic [7:0] OP_MOVR = 8'd6;
   localparam logic [7:0] OP_CLAC = 8'd7;
   localparam logic [7:0] OP_ADD  = 8'd8;
   localparam logic [7:0] OP_SUB  = 8'd9;
   localparam logic [7:0] OP_AND  = 8'd10;
   localparam logic [7:0] OP_OR   = 8'd11;
   localparam logic [7:0] OP_XOR  = 8'd12;
   localparam logic [7:0] OP_NOT  = 8'd13;
   localparam logic [7:0] OP_INAC = 8'd19;
   localparam logic [7:0] OP_JUMP = 8'd29;
   localparam logic [7:0] OP_JMPZ = 8'd32;
   localparam logic [7:0] OP_JMNZ = 8'd37;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DECODE,
      ST_OPADDR,
      ST_OPDATA,
      ST_BRWAIT,
      ST_ISSUE,
      ST_HALT
   } fetch_state_t;

   function automatic logic is_branch(input logic [7:0] op);
      return (op == OP_JUMP) || (op == OP_JMPZ) || (op == OP_JMNZ);
   endfunction

endpackage

// File: rtl/instr_fetch_unit_branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
// Combinational branch decision for JUMP / JMPZ / JMNZ.
// Ports:
//   opcode   in  8  branch opcode held in the IR
//   z_flag   in  1  ALU zero flag (sampled by the caller when exec_idle is seen)
//   target   in  8  operand byte fetched after the opcode
//   ptr      in  8  address of the branch opcode
//   next_ptr out 8  target when taken, otherwise ptr+2 (8-bit wrap)
// -----------------------------------------------------------------------------
module branch_resolve
   import isa_pkg::*;
(
   input  logic [7:0] opcode,
   input  logic       z_flag,
   input  logic [7:0] target,
   input  logic [7:0] ptr,
   output logic [7:0] next_ptr
);

   logic taken;

   always_comb begin
      taken = 1'b0;
      case (opcode)
         OP_JUMP: taken = 1'b1;
         OP_JMPZ: taken = z_flag;
         OP_JMNZ: taken = ~z_flag;
         default: taken = 1'b0;
      endcase
   end

   // Not-taken skips both the opcode and its operand byte.
   assign next_ptr = taken ? target : (ptr + 8'd2);

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Owns the PC, reads the registered IRAM, resolves JUMP/JMPZ/JMNZ locally and
// hands every other opcode to the control unit over a valid/ready handshake.
// Optional feature macro: IFU_RETIRE_COUNT_EN (adds retire_cnt output).
// Ports:
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   start        in   1  begin fetching at RESET_PC (accepted in IDLE/HALT only)
//   rom_addr     out  8  IRAM address (always the registered fetch pointer)
//   rom_dout     in   8  IRAM data, valid one cycle after rom_addr is sampled
//   instr        out  8  opcode to the control unit
//   instr_valid  out  1  instr is valid
//   instr_ready  in   1  control unit accepts instr
//   exec_idle    in   1  last accepted instruction finished, z_flag settled
//   z_flag       in   1  ALU zero flag
//   pc           out  8  opcode address of the instruction held/issued
//   halted       out  1  fetch stopped (NOP or fault)
//   fault        out  1  fetch address out of range
//   retire_cnt   out 16  (IFU_RETIRE_COUNT_EN only) saturating retire count
// -----------------------------------------------------------------------------
module instr_fetch_unit
   import isa_pkg::*;
#(
   parameter int unsigned ROM_DEPTH   = 121,
   parameter logic [7:0]  RESET_PC    = 8'd0,
   parameter bit          HALT_ON_NOP = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [7:0]  rom_addr,
   input  logic [7:0]  rom_dout,
   output logic [7:0]  instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        exec_idle,
   input  logic        z_flag,
   output logic [7:0]  pc,
   output logic        halted,
   output logic        fault
`ifdef IFU_RETIRE_COUNT_EN
   ,
   output logic [15:0] retire_cnt
`endif
);

   fetch_state_t state;
   logic [7:0]   fetch_ptr;   // drives rom_addr directly
   logic [7:0]   pc_q;        // opcode address of the current instruction
   logic [7:0]   ir;          // captured opcode
   logic [7:0]   tgt;         // captured branch operand
   logic [7:0]   instr_q;
   logic         valid_q;
   logic         halted_q;
   logic         fault_q;
   logic [7:0]   pc_inc;
   logic [7:0]   br_next;

   function automatic logic in_range(input logic [7:0] a);
      return ({24'd0, a} < ROM_DEPTH);
   endfunction

   assign pc_inc = pc_q + 8'd1;

   branch_resolve u_branch_resolve (
      .opcode   (ir),
      .z_flag   (z_flag),
      .target   (tgt),
      .ptr      (pc_q),
      .next_ptr (br_next)
   );

   // Every transition into ADDR/OPADDR is gated by in_range(); an out-of-range
   // address goes straight to HALT and fetch_ptr keeps its old value, so the
   // faulting address never reaches the IRAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         fetch_ptr <= RESET_PC;
         pc_q      <= RESET_PC;
         ir        <= '0;
         tgt       <= '0;
         instr_q   <= '0;
         valid_q   <= 1'b0;
         halted_q  <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  pc_q <= RESET_PC;
                  if (in_range(RESET_PC)) begin
                     halted_q  <= 1'b0;
                     fault_q   <= 1'b0;
                     fetch_ptr <= RESET_PC;
                     state     <= ST_ADDR;
                  end else begin
                     halted_q <= 1'b1;
                     fault_q  <= 1'b1;
                     state    <= ST_HALT;
                  end
               end
            end
            ST_ADDR: begin
               state <= ST_DATA;
            end
            ST_DATA: begin
               ir    <= rom_dout;
               state <= ST_DECODE;
            end
            ST_DECODE: begin
               if (is_branch(ir)) begin
                  if (in_range(pc_inc)) begin
                     fetch_ptr <= pc_inc;
                     state     <= ST_OPADDR;
                  end else begin
                     halted_q <= 1'b1;
                     fault_q  <= 1'b1;
                     state    <= ST_HALT;
                  end
               end else if (HALT_ON_NOP && (ir == OP_NOP)) begin
                  halted_q <= 1'b1;
                  state    <= ST_HALT;
               end else begin
                  instr_q <= ir;
                  valid_q <= 1'b1;
                  state   <= ST_ISSUE;
               end
            end
            ST_OPADDR: begin
               state <= ST_OPDATA;
            end
            ST_OPDATA: begin
               tgt   <= rom_dout;
               state <= ST_BRWAIT;
            end
            ST_BRWAIT: begin
               // z_flag is only trusted once the control unit reports idle.
               if (exec_idle) begin
                  if (in_range(br_next)) begin
                     fetch_ptr <= br_next;
                     pc_q      <= br_next;
                     state     <= ST_ADDR;
                  end else begin
                     halted_q <= 1'b1;
                     fault_q  <= 1'b1;
                     state    <= ST_HALT;
                  end
               end
            end
            ST_ISSUE: begin
               if (instr_ready) begin
                  valid_q <= 1'b0;
                  if (in_range(pc_inc)) begin
                     fetch_ptr <= pc_inc;
                     pc_q      <= pc_inc;
                     state     <= ST_ADDR;
                  end else begin
                     halted_q <= 1'b1;
                     fault_q  <= 1'b1;
                     state    <= ST_HALT;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rom_addr    = fetch_ptr;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign halted      = halted_q;
   assign fault       = fault_q;

`ifdef IFU_RETIRE_COUNT_EN
   logic [15:0] retire_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_q <= '0;
      end else if (((state == ST_IDLE) || (state == ST_HALT)) && start) begin
         retire_q <= '0;
      end else if (((state == ST_ISSUE) && instr_ready) ||
                   ((state == ST_BRWAIT) && exec_idle)) begin
         if (retire_q != 16'hFFFF) begin
            retire_q <= retire_q + 16'd1;
         end
      end
   end

   assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed scenarios followed by random programs compared against an
// instruction-level model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam logic [7:0] T_NOP  = 8'd2;
   localparam logic [7:0] T_CLAC = 8'd7;
   localparam logic [7:0] T_INAC = 8'd19;
   localparam logic [7:0] T_JUMP = 8'd29;
   localparam logic [7:0] T_JMPZ = 8'd32;
   localparam logic [7:0] T_JMNZ = 8'd37;
   localparam int         DEPTH  = 121;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] rom_addr;
   logic [7:0] rom_dout = 8'd0;
   logic [7:0] instr;
   logic       instr_valid;
   logic       instr_ready;
   logic       exec_idle;
   logic       z_flag;
   logic [7:0] pc;
   logic       halted;
   logic       fault;
`ifdef IFU_RETIRE_COUNT_EN
   logic [15:0] retire_cnt;
`endif

   logic [7:0]  rom [0:255];
   int          checks = 0;
   int          errors = 0;
   int          rd200 = 0;
   int          br_issued = 0;
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];

   instr_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .rom_addr    (rom_addr),
      .rom_dout    (rom_dout),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .exec_idle   (exec_idle),
      .z_flag      (z_flag),
      .pc          (pc),
      .halted      (halted),
      .fault       (fault)
`ifdef IFU_RETIRE_COUNT_EN
      ,
      .retire_cnt  (retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Registered IRAM
   always @(posedge clk) rom_dout <= rom[rom_addr];

   always @(posedge clk) begin
      if (rom_addr == 8'd200) rd200 <= rd200 + 1;
      if (instr_valid && (instr == T_JUMP || instr == T_JMPZ || instr == T_JMNZ))
         br_issued <= br_issued + 1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      instr_ready = 1'b0;
      exec_idle = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic fill_rom(input logic [7:0] v);
      for (int a = 0; a < 256; a++) rom[a] = v;
   endtask

   // Counts negedges until instr_valid or halted (bounded); drops start.
   task automatic wait_valid(input int max, output int n);
      n = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         n++;
      end while (!instr_valid && !halted && n < max);
   endtask

   task automatic wait_addr(input logic [7:0] a, input int max, output bit found);
      found = 1'b0;
      for (int i = 0; i < max && !found; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (rom_addr == a) found = 1'b1;
      end
   endtask

   // Instruction-level model: walk the program by the fetch rules.
   function automatic void model_run(input logic z, output logic fault_o);
      logic [7:0] p, q, op, t;
      bit         tk;
      bit         stop;
      exp_q.delete();
      fault_o = 1'b0;
      stop = 1'b0;
      p = 8'd0;
      for (int s = 0; s < 400 && !stop; s++) begin
         if (int'(p) >= DEPTH) begin
            fault_o = 1'b1;
            stop = 1'b1;
         end else begin
            op = rom[p];
            if (op == T_JUMP || op == T_JMPZ || op == T_JMNZ) begin
               q = p + 8'd1;
               if (int'(q) >= DEPTH) begin
                  fault_o = 1'b1;
                  stop = 1'b1;
               end else begin
                  t = rom[q];
                  tk = (op == T_JUMP) || (op == T_JMPZ && z) || (op == T_JMNZ && !z);
                  p = tk ? t : (p + 8'd2);
               end
            end else if (op == T_NOP) begin
               stop = 1'b1;
            end else begin
               exp_q.push_back({op, p});
               p = p + 8'd1;
            end
         end
      end
   endfunction

   // Forward-only branches keep every program finite.
   task automatic gen_program();
      logic [7:0] ops [8];
      int r, t;
      ops = '{8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd11, 8'd19, 8'd13};
      for (int a = 0; a < 256; a++) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            rom[a] = T_NOP;
         end else if (r < 15 && a < 255) begin
            case ($urandom_range(0, 2))
               0: rom[a] = T_JUMP;
               1: rom[a] = T_JMPZ;
               default: rom[a] = T_JMNZ;
            endcase
            do t = a + 2 + $urandom_range(0, 30);
            while (t == 2 || t == 29 || t == 32 || t == 37);
            rom[a + 1] = t[7:0];
            a++;
         end else begin
            rom[a] = ops[$urandom_range(0, 7)];
         end
      end
   endtask

   task automatic run_random(input int idx);
      logic        exp_fault;
      logic        zv;
      bit          done, pend;
      logic [15:0] pend_v;
      int          nmin;
      gen_program();
      zv = $urandom_range(0, 1);
      z_flag = zv;
      model_run(zv, exp_fault);
      do_reset();
      got_q.delete();
      done = 1'b0;
      pend = 1'b0;
      pend_v = '0;
      start = 1'b1;
      for (int c = 0; c < 6000 && !done; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (pend) begin
            check($sformatf("r%0d_hold_valid", idx), instr_valid, 1);
            check($sformatf("r%0d_hold_data", idx), {instr, pc}, pend_v);
         end
         pend = 1'b0;
         if (halted) begin
            done = 1'b1;
            instr_ready = 1'b0;
            exec_idle = 1'b0;
         end else begin
            exec_idle = ($urandom_range(0, 3) == 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            if (instr_valid) begin
               if (instr_ready) got_q.push_back({instr, pc});
               else begin
                  pend = 1'b1;
                  pend_v = {instr, pc};
               end
            end
         end
      end
      check($sformatf("r%0d_halted", idx), done, 1);
      check($sformatf("r%0d_halt_novalid", idx), instr_valid, 0);
      check($sformatf("r%0d_count", idx), got_q.size(), exp_q.size());
      nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nmin; i++)
         check($sformatf("r%0d_seq%0d", idx, i), got_q[i], exp_q[i]);
      check($sformatf("r%0d_fault", idx), fault, exp_fault);
   endtask

   initial begin
      int n;
      bit found;
      int r0;
      int vcount;
      rst_n = 1'b0;
      start = 1'b0;
      instr_ready = 1'b0;
      exec_idle = 1'b0;
      z_flag = 1'b0;
      fill_rom(T_CLAC);
      do_reset();

      // Reset values
      check("rst_rom_addr", rom_addr, 0);
      check("rst_instr", instr, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_pc", pc, 0);
      check("rst_halted", halted, 0);
      check("rst_fault", fault, 0);

      // CLAC, INAC (stalled 5 cycles), NOP
      fill_rom(T_CLAC);
      rom[0] = T_CLAC; rom[1] = T_INAC; rom[2] = T_NOP;
      start = 1'b1;
      wait_valid(20, n);
      check("lat_first", n, 4);
      check("first_valid", instr_valid, 1);
      check("first_instr", instr, T_CLAC);
      check("first_pc", pc, 0);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      check("acc1_valid", instr_valid, 0);
      check("acc1_addr", rom_addr, 1);
      wait_valid(20, n);
      check("lat_second", n, 3);
      check("second_instr", instr, T_INAC);
      check("second_pc", pc, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", instr_valid, 1);
         check("stall_instr", instr, T_INAC);
         check("stall_addr", rom_addr, 1);
      end
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      check("acc2_valid", instr_valid, 0);
      check("acc2_addr", rom_addr, 2);
      wait_valid(20, n);
      check("nop_halted", halted, 1);
      check("nop_novalid", instr_valid, 0);
      check("nop_nofault", fault, 0);
      repeat (3) @(negedge clk);
      check("nop_still_novalid", instr_valid, 0);

      // JMPZ taken with delayed exec_idle
      fill_rom(T_CLAC);
      rom[0] = T_INAC; rom[1] = T_CLAC; rom[2] = T_INAC; rom[3] = T_INAC; rom[4] = T_CLAC;
      rom[5] = T_JMPZ; rom[6] = 8'd120; rom[120] = T_NOP;
      do_reset();
      z_flag = 1'b1;
      instr_ready = 1'b1;
      start = 1'b1;
      wait_addr(8'd6, 80, found);
      check("jmpz_opfetch", found, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("jmpz_wait_addr", rom_addr, 6);
      end
      exec_idle = 1'b1;
      @(negedge clk);
      exec_idle = 1'b0;
      check("jmpz_target", rom_addr, 120);
      check("jmpz_pc", pc, 120);
      wait_valid(20, n);
      check("jmpz_halted", halted, 1);
      check("jmpz_nofault", fault, 0);

      // JMNZ not taken with z=1
      fill_rom(T_CLAC);
      rom[5] = T_JMNZ; rom[6] = 8'd21; rom[7] = T_NOP; rom[21] = T_NOP;
      do_reset();
      z_flag = 1'b1;
      instr_ready = 1'b1;
      start = 1'b1;
      wait_addr(8'd6, 80, found);
      check("jmnz_opfetch", found, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("jmnz_wait_addr", rom_addr, 6);
      end
      exec_idle = 1'b1;
      @(negedge clk);
      exec_idle = 1'b0;
      check("jmnz_next", rom_addr, 7);
      check("jmnz_pc", pc, 7);
      check("branch_never_issued", br_issued, 0);

      // JUMP out of range
      fill_rom(T_CLAC);
      rom[0] = T_JUMP; rom[1] = 8'd200;
      do_reset();
      r0 = rd200;
      exec_idle = 1'b1;
      start = 1'b1;
      wait_valid(30, n);
      check("jfault_fault", fault, 1);
      check("jfault_halted", halted, 1);
      check("jfault_no_read", rd200, r0);
      exec_idle = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_fault", fault, 0);
      check("restart_halted", halted, 0);
      check("restart_addr", rom_addr, 0);

      // Asynchronous reset in DATA and during a held handshake
      fill_rom(T_CLAC);
      rom[0] = T_INAC; rom[1] = T_CLAC; rom[2] = T_NOP;
      do_reset();
      instr_ready = 1'b1;
      start = 1'b1;
      wait_addr(8'd1, 40, found);
      check("mid_reach", found, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_addr", rom_addr, 0);
      check("arst_pc", pc, 0);
      check("arst_valid", instr_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      vcount = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (instr_valid) vcount++;
      end
      check("arst_no_stale", vcount, 0);
      instr_ready = 1'b0;
      start = 1'b1;
      wait_valid(20, n);
      check("hs_valid", instr_valid, 1);
      rst_n = 1'b0;
      #1;
      check("hs_arst_valid", instr_valid, 0);
      check("hs_arst_instr", instr, 0);
      check("hs_arst_addr", rom_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Random programs against the model
      for (int k = 0; k < 8; k++) run_random(k);
      check("random_branch_never_issued", br_issued, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the IRAM read interface: owns the PC, drives the IRAM address and captures the registered IRAM byte a cycle later.
- Resolves JUMP/JMPZ/JMNZ (opcode byte plus target byte) internally.
- Hands every other opcode to the control unit through a valid/ready handshake.
- Sits between the IRAM and the control-unit FSM; replaces the ad-hoc PC/MBRU fetch states.

Parameters:
- ROM_DEPTH, 121, number of valid IRAM words; fetch address >= ROM_DEPTH is a fault.
- RESET_PC, 8'd0, PC value after reset and on start.
- HALT_ON_NOP, 1, 1 = opcode NOP (8'd2) stops fetching and asserts halted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins fetching from RESET_PC when idle or halted.
- rom_addr  out  8  IRAM address.
- rom_dout  in  8  IRAM data, valid one cycle after rom_addr is sampled.
- instr  out  8  opcode to control unit.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  control unit accepts instr.
- exec_idle  in  1  control unit has finished the last accepted instruction; z_flag is settled.
- z_flag  in  1  ALU zero flag.
- pc  out  8  address of the instruction currently held or issued.
- halted  out  1  fetch stopped (NOP or fault).
- fault  out  1  fetch address out of range.

Behaviour:
- Reset values: rom_addr=RESET_PC, instr=0, instr_valid=0, pc=RESET_PC, halted=0, fault=0, state=IDLE.
- rom_addr is always driven from an internal fetch pointer register, never combinationally from rom_dout.
- States:
  - IDLE: wait for start.
  - ADDR: pointer on rom_addr; IRAM samples at this edge.
  - DATA: rom_dout valid; capture into IR.
  - DECODE: classify opcode.
  - OPADDR / OPDATA: fetch target byte at pointer+1.
  - BRWAIT: wait for exec_idle.
  - ISSUE: instr_valid high.
  - HALT: stopped.
- Fetch latency: 2 cycles from pointer update to IR capture (ADDR, DATA). Non-branch opcode reaches instr_valid 3 cycles after ADDR.
- ISSUE:
  - instr_valid is held with instr stable until instr_ready is high at a clock edge.
  - On that edge: pointer <= pointer+1, go to ADDR.
  - instr_ready while instr_valid=0 is ignored.
- Branch opcodes (JUMP=29, JMPZ=32, JMNZ=37) are never issued to the control unit.
  - Target fetched at pointer+1 (2 cycles), then BRWAIT until exec_idle=1.
  - z_flag is sampled in the same cycle exec_idle=1 is observed.
  - Taken (JUMP always; JMPZ if z=1; JMNZ if z=0): pointer <= target.
  - Not taken: pointer <= pointer+2.
- NOP with HALT_ON_NOP=1: go to HALT, halted=1, no instr_valid. With HALT_ON_NOP=0, NOP is issued normally.
- Fault: pointer >= ROM_DEPTH on entry to ADDR (including branch target or operand address) → HALT with fault=1; no IRAM read is issued.
- Pointer arithmetic is 8-bit and wraps (255+1=0); the wrap is then subject to the fault check.
- start in HALT or IDLE clears halted/fault and reloads RESET_PC. start in any other state is ignored.
- Reset mid-fetch or mid-handshake: all outputs return to reset values immediately (asynchronous), in-flight IRAM data is discarded.
- pc equals the opcode address of the held instruction, not the operand address.

Optional Feature:
- Macro IFU_RETIRE_COUNT_EN.
- Defined: adds output retire_cnt[15:0].
  - Increments on every instr_valid&&instr_ready handshake and on every resolved branch.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by an accepted start.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package isa_pkg: opcode constants (NOP, JUMP, JMPZ, JMNZ and the rest of the ISA, 8 bits), fetch state enum typedef.
- Sub-module branch_resolve (combinational: opcode, z_flag, target, pointer → next pointer, taken flag) is natural. Everything else stays in one module.

Test Plan:
- Load IRAM {0:CLAC(7), 1:INAC(19), 2:NOP}, pulse start, instr_ready=1 → instr 7 then 19 issued, pc=0 then 1; halted=1 after NOP fetch, no third instr_valid.
- instr_ready held 0 for 5 cycles on INAC → instr_valid and instr=19 stable for all 5 cycles; rom_addr unchanged until the accepting edge.
- ROM[5]=JMPZ, ROM[6]=120, z_flag=1, exec_idle delayed 3 cycles → no fetch until exec_idle; next rom_addr=120; instr_valid never shows 32.
- Same with JMNZ(37) target 21, z_flag=1 → not taken, next rom_addr=7.
- JUMP to 200 with ROM_DEPTH=121 → fault=1, halted=1, no IRAM read at 200; start pulse → fault=0, rom_addr=0.
- Deassert rst_n mid-DATA state → instr_valid=0, rom_addr=0 asynchronously; no stale instr issued after release until start.
